// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: issues one outstanding word read at a time and
// queues returned {instr, pc+4} pairs ahead of the IF/ID register.
module instr_fetch_queue #(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 7,
  parameter int RESET_PC = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ready,
  input  logic                     mem_rvalid,
  input  logic [31:0]              mem_rdata,
  output logic                     if_valid,
  output logic [31:0]              if_instr,
  output logic [ADDR_W-1:0]        if_pc_inc,
  input  logic                     if_stall,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_target,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]     FULL    = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] WORD    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              pending;
  logic              discard;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [31:0]       instr_q  [DEPTH];
  logic [ADDR_W-1:0] pc_inc_q [DEPTH];

  logic issue;
  logic resp;
  logic push;
  logic pop;

  // Handshakes: a request transfers when mem_req && mem_ready; a response is
  // only accepted while a request is outstanding; the head pops when
  // if_valid && !if_stall, and redirect overrides issue, push and pop.
  assign mem_req  = !reset && !redirect && !pending && (count < FULL);
  assign mem_addr = fetch_pc;
  assign issue    = mem_req && mem_ready;
  assign resp     = mem_rvalid && pending;
  assign push     = resp && !discard && !redirect;
  assign pop      = (count != '0) && !if_stall && !redirect;

  assign if_valid  = (count != '0);
  assign if_instr  = instr_q[rd_ptr];
  assign if_pc_inc = pc_inc_q[rd_ptr];
  assign q_count   = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= PC_INIT;
      req_pc   <= '0;
      pending  <= 1'b0;
      discard  <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (resp) pending <= 1'b0;
      if (redirect) begin
        fetch_pc <= redirect_target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        // A response landing in this same cycle is already dropped here.
        discard  <= pending && !mem_rvalid;
      end else begin
        if (issue) begin
          pending  <= 1'b1;
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + WORD;
        end
        if (resp) discard <= 1'b0;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr]  <= mem_rdata;
      pc_inc_q[wr_ptr] <= req_pc + WORD;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a latency-programmable memory model
// returning 0xA000_0000 + address for each word read.
module tb_instr_fetch_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready = 1'b1;
  logic              mem_rvalid = 1'b0;
  logic [31:0]       mem_rdata = '0;
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [ADDR_W-1:0] if_pc_inc;
  logic              if_stall = 1'b0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_target = '0;
  logic [2:0]        q_count;

  int checks = 0;
  int errors = 0;
  int lat = 1;

  logic              busy = 1'b0;
  int                cd = 0;
  logic [ADDR_W-1:0] r_addr = '0;

  logic [ADDR_W-1:0] hs_q[$];
  logic [31:0]       ins_q[$];
  logic [ADDR_W-1:0] inc_q[$];
  logic [ADDR_W-1:0] exp_hs  [3] = '{7'h78, 7'h7C, 7'h00};
  logic [ADDR_W-1:0] exp_inc [3] = '{7'h7C, 7'h00, 7'h04};

  instr_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc_inc(if_pc_inc),
    .if_stall(if_stall), .redirect(redirect), .redirect_target(redirect_target),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [ADDR_W-1:0] a);
    return 32'hA000_0000 + 32'(a);
  endfunction

  // Memory model: response is valid `lat` cycles after the handshake cycle.
  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (busy && cd == 1) begin
      mem_rvalid <= 1'b1;
      mem_rdata  <= word(r_addr);
      busy       <= 1'b0;
    end else if (busy) begin
      cd <= cd - 1;
    end
    if (mem_req && mem_ready) begin
      if (lat == 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= word(mem_addr);
      end else begin
        busy   <= 1'b1;
        cd     <= lat - 1;
        r_addr <= mem_addr;
      end
    end
  end

  task automatic next_cycle;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic stall);
    next_cycle();
    reset = 1'b1; redirect = 1'b0; if_stall = stall; mem_ready = 1'b1;
    repeat (4) next_cycle();
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (if_valid) begin ok = 1'b1; break; end
      next_cycle();
    end
  endtask

  task automatic test_reset;
    next_cycle();
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", q_count); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b exp 0", if_valid); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b exp 0", mem_req); end
  endtask

  task automatic test_run;
    bit ok;
    lat = 1;
    do_reset(1'b0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 7'd0) begin errors++; $display("FAIL run_first_req: got req=%0b addr=%0h exp req=1 addr=0", mem_req, mem_addr); end
    next_cycle();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL run_no_bypass: got valid=%0b exp 0", if_valid); end
    next_cycle();
    checks++; if (if_valid !== 1'b1 || if_instr !== 32'hA000_0000 || if_pc_inc !== 7'd4) begin
      errors++; $display("FAIL run_first_entry: got v=%0b instr=%h inc=%0h exp v=1 instr=a0000000 inc=4", if_valid, if_instr, if_pc_inc); end
    for (int a = 4; a <= 12; a += 4) begin
      next_cycle();
      wait_valid(10, ok);
      checks++; if (!ok || if_instr !== word(ADDR_W'(a)) || if_pc_inc !== ADDR_W'(a + 4)) begin
        errors++; $display("FAIL run_entry_%0d: got v=%0b instr=%h inc=%0h exp instr=%h inc=%0h", a, ok, if_instr, if_pc_inc, word(ADDR_W'(a)), a + 4); end
    end
  endtask

  task automatic test_stall;
    lat = 1;
    do_reset(1'b1);
    repeat (20) next_cycle();
    checks++; if (q_count !== 3'd4 || mem_req !== 1'b0) begin errors++; $display("FAIL stall_full: got count=%0d req=%0b exp count=4 req=0", q_count, mem_req); end
    checks++; if (if_valid !== 1'b1 || if_instr !== 32'hA000_0000 || if_pc_inc !== 7'd4) begin
      errors++; $display("FAIL stall_head: got v=%0b instr=%h inc=%0h exp v=1 instr=a0000000 inc=4", if_valid, if_instr, if_pc_inc); end
    if_stall = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (if_valid !== 1'b1 || if_instr !== word(ADDR_W'(4 * k)) || if_pc_inc !== ADDR_W'(4 * k + 4)) begin
        errors++; $display("FAIL stall_drain_%0d: got v=%0b instr=%h inc=%0h exp instr=%h", k, if_valid, if_instr, if_pc_inc, word(ADDR_W'(4 * k))); end
      if (k == 1) begin
        checks++; if (mem_req !== 1'b1 || mem_addr !== 7'd16) begin errors++; $display("FAIL stall_resume: got req=%0b addr=%0h exp req=1 addr=10", mem_req, mem_addr); end
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect_pending;
    bit ok;
    lat = 3;
    do_reset(1'b1);
    for (int i = 0; i < 40 && q_count != 3'd4; i++) next_cycle();
    checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL rp_fill: got count=%0d exp 4", q_count); end
    if_stall = 1'b0;
    next_cycle();
    if_stall = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 7'h10 || q_count !== 3'd3) begin
      errors++; $display("FAIL rp_issue: got req=%0b addr=%0h count=%0d exp req=1 addr=10 count=3", mem_req, mem_addr, q_count); end
    next_cycle();
    redirect = 1'b1; redirect_target = 7'h40;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rp_redirect_req: got %0b exp 0", mem_req); end
    next_cycle();
    redirect = 1'b0; if_stall = 1'b0;
    #1;
    checks++; if (q_count !== 3'd0 || if_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL rp_flush: got count=%0d v=%0b req=%0b exp 0 0 0", q_count, if_valid, mem_req); end
    next_cycle();
    next_cycle();
    checks++; if (q_count !== 3'd0 || mem_req !== 1'b1 || mem_addr !== 7'h40) begin
      errors++; $display("FAIL rp_drop: got count=%0d req=%0b addr=%0h exp count=0 req=1 addr=40", q_count, mem_req, mem_addr); end
    wait_valid(20, ok);
    checks++; if (!ok || if_instr !== 32'hA000_0040 || if_pc_inc !== 7'h44) begin
      errors++; $display("FAIL rp_target_entry: got v=%0b instr=%h inc=%0h exp instr=a0000040 inc=44", ok, if_instr, if_pc_inc); end
  endtask

  task automatic test_redirect_same_cycle;
    bit ok;
    bit found = 1'b0;
    lat = 1;
    do_reset(1'b1);
    for (int i = 0; i < 20; i++) begin
      if (mem_rvalid && if_valid) begin found = 1'b1; break; end
      next_cycle();
    end
    checks++; if (!found) begin errors++; $display("FAIL rs_setup: got no rvalid with valid head, exp one"); end
    redirect = 1'b1; redirect_target = 7'h20; if_stall = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rs_redirect_req: got %0b exp 0", mem_req); end
    next_cycle();
    redirect = 1'b0;
    #1;
    checks++; if (q_count !== 3'd0 || if_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 7'h20) begin
      errors++; $display("FAIL rs_after: got count=%0d v=%0b req=%0b addr=%0h exp 0 0 1 20", q_count, if_valid, mem_req, mem_addr); end
    wait_valid(20, ok);
    checks++; if (!ok || if_instr !== 32'hA000_0020 || if_pc_inc !== 7'h24) begin
      errors++; $display("FAIL rs_entry: got v=%0b instr=%h inc=%0h exp instr=a0000020 inc=24", ok, if_instr, if_pc_inc); end
  endtask

  task automatic test_wrap;
    hs_q.delete(); ins_q.delete(); inc_q.delete();
    next_cycle();
    redirect = 1'b1; redirect_target = 7'h78;
    next_cycle();
    redirect = 1'b0;
    #1;
    for (int i = 0; i < 40 && ins_q.size() < 3; i++) begin
      if (mem_req && mem_ready) hs_q.push_back(mem_addr);
      if (if_valid && !if_stall) begin ins_q.push_back(if_instr); inc_q.push_back(if_pc_inc); end
      next_cycle();
    end
    checks++; if (hs_q.size() < 3 || ins_q.size() < 3) begin
      errors++; $display("FAIL wrap_count: got reqs=%0d pops=%0d exp at least 3 each", hs_q.size(), ins_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (hs_q[k] !== exp_hs[k] || inc_q[k] !== exp_inc[k] || ins_q[k] !== word(exp_hs[k])) begin
          errors++; $display("FAIL wrap_%0d: got addr=%0h inc=%0h instr=%h exp addr=%0h inc=%0h instr=%h",
                             k, hs_q[k], inc_q[k], ins_q[k], exp_hs[k], exp_inc[k], word(exp_hs[k])); end
      end
    end
  endtask

  task automatic test_reset_pending;
    bit ok;
    lat = 3;
    do_reset(1'b0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 7'd0) begin errors++; $display("FAIL rst_issue: got req=%0b addr=%0h exp 1 0", mem_req, mem_addr); end
    next_cycle();
    reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || q_count !== 3'd0) begin errors++; $display("FAIL rst_during: got req=%0b count=%0d exp 0 0", mem_req, q_count); end
    next_cycle();
    reset = 1'b0; mem_ready = 1'b0;
    next_cycle();
    next_cycle();
    checks++; if (q_count !== 3'd0 || if_valid !== 1'b0) begin errors++; $display("FAIL rst_stray: got count=%0d v=%0b exp 0 0", q_count, if_valid); end
    mem_ready = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 7'd0) begin errors++; $display("FAIL rst_refetch: got req=%0b addr=%0h exp 1 0", mem_req, mem_addr); end
    wait_valid(20, ok);
    checks++; if (!ok || if_instr !== 32'hA000_0000 || if_pc_inc !== 7'd4) begin
      errors++; $display("FAIL rst_entry: got v=%0b instr=%h inc=%0h exp instr=a0000000 inc=4", ok, if_instr, if_pc_inc); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_run();
    test_stall();
    test_redirect_pending();
    test_redirect_same_cycle();
    test_wrap();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Instruction fetch front end that sits directly upstream of the IF/ID pipeline register of the 5-stage 32-bit core.
- Generates fetch addresses and issues single-outstanding word reads to the instruction memory port.
- Buffers returned instructions, each paired with its PC+4, in a small prefetch FIFO.
- Honours the decode stall (hold) and jump redirect (PCSrc) requests by holding or flushing the FIFO.

Parameters:
- DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.
- ADDR_W, 7, byte-address width of the PC and instruction memory.
- RESET_PC, 0, fetch address loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  read request valid.
- mem_addr  out  ADDR_W  byte address of the requested word, big-endian, 4-byte aligned by construction.
- mem_ready  in  1  memory accepts the request; a handshake occurs when mem_req && mem_ready.
- mem_rvalid  in  1  read data valid; arrives one or more cycles after the handshake.
- mem_rdata  in  32  instruction word; bits [31:24] are at mem_addr.
- if_valid  out  1  head FIFO entry available to IF/ID.
- if_instr  out  32  head instruction.
- if_pc_inc  out  ADDR_W  head entry's address + 4, modulo 2^ADDR_W.
- if_stall  in  1  IF/ID not loading (hazard stall); the head is held.
- redirect  in  1  taken jump; flush and refetch.
- redirect_target  in  ADDR_W  new fetch address (JumpAddress[6:0]).
- q_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, highest priority):
  - Clears pending and discard; sets fetch_pc = RESET_PC.
  - Empties the FIFO, so q_count = 0, if_valid = 0 and mem_req = 0 during the reset cycle.
  - Reset mid-operation abandons any in-flight request. A later mem_rvalid that arrives while pending = 0 is ignored.
- State:
  - fetch_pc
  - pending, one request outstanding
  - discard, the outstanding response must be dropped
  - req_pc, address of the outstanding request
  - FIFO storage {instr, pc_inc} with rd_ptr, wr_ptr, count
- Issue:
  - mem_req = !reset && !redirect && !pending && (count < DEPTH); mem_addr = fetch_pc.
  - On handshake: pending <= 1, req_pc <= fetch_pc, fetch_pc <= fetch_pc + 4.
  - The add wraps modulo 2^ADDR_W, so 124 + 4 = 0.
- Response:
  - When mem_rvalid && pending: pending <= 0.
  - If !discard, push {mem_rdata, req_pc + 4}.
  - If discard, drop the data and clear discard.
- No bypass: a pushed word is visible on if_valid/if_instr starting the following cycle.
- Pop:
  - if_valid = (count != 0); if_instr and if_pc_inc come from the head (registered storage).
  - Pop occurs when if_valid && !if_stall && !redirect.
  - Simultaneous push and pop leaves count unchanged.
  - Overflow is impossible: issue requires count < DEPTH and only one request is outstanding.
- Redirect (priority over pop, push and issue in the same cycle):
  - Empties the FIFO (count <= 0) and sets fetch_pc <= redirect_target.
  - If pending, sets discard <= 1.
  - A response arriving in the redirect cycle itself is dropped and clears pending.
  - The next request issues on the first cycle after the redirect with pending = 0.
  - A redirect while discard is already 1 keeps discard = 1 and takes the newest target.
- Stall: the FIFO keeps filling up to DEPTH while if_stall = 1, and the head output is stable.
- Throughput: with single-cycle memory (rvalid the cycle after the handshake), one request every 2 cycles.

Test Plan:
- Reset then run, mem_ready = 1, 1-cycle latency, memory word at addr n = 0xA000_0000 + n:
  - Cycle 0: mem_addr 0.
  - if_valid rises 2 cycles after the first handshake with if_instr 0xA0000000 and if_pc_inc 4.
  - Subsequent entries appear in order for addrs 4, 8, 12.
- Hold if_stall = 1 for 20 cycles:
  - q_count saturates at 4 and mem_req stays low.
  - Head stays at addr 0.
  - Release if_stall: entries 0, 4, 8, 12 pop on consecutive cycles, then fetching resumes at 16.
- Redirect with target 0x40 while a request to 0x10 is outstanding (3-cycle latency):
  - The 0x10 response is dropped and q_count goes to 0.
  - Next mem_addr is 0x40, and the first if_instr after the redirect is word 0x40 with if_pc_inc 0x44.
- Redirect in the same cycle as mem_rvalid and a pop:
  - FIFO is empty next cycle and the returned word never appears.
  - Next request goes to redirect_target.
- Wrap: redirect to 0x78:
  - Fetch sequence 0x78, 0x7C, 0x00.
  - if_pc_inc values 0x7C, 0x00, 0x04.
- Reset asserted while pending, followed by a stray mem_rvalid:
  - Stray response ignored and q_count stays 0.
  - First post-reset request goes to RESET_PC.
